// File: rtl/dmem_sync_if.sv
// Request/response bundle between the MEM stage and dmem_sync.
interface dmem_sync_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              MEMR;
  logic              MEMW;
  logic [3:0]        MEM_Ctrl;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dataW;
  logic              rsp_valid;
  logic [31:0]       dataR;
  logic              misalign_fault;

  modport master (
    output req_valid, MEMR, MEMW, MEM_Ctrl, addr, dataW,
    input  req_ready, rsp_valid, dataR, misalign_fault
  );

  modport slave (
    input  req_valid, MEMR, MEMW, MEM_Ctrl, addr, dataW,
    output req_ready, rsp_valid, dataR, misalign_fault
  );
endinterface

// File: rtl/dmem_sync.sv
// Byte-enabled synchronous-read data memory for RISC-V loads/stores.
// DMEM_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats instead of faulting misaligned ones.
//
// state | meaning
// IDLE  | accepting requests; non-crossing accesses complete here
// BEAT2 | second word of a crossing access (split build only)
module dmem_sync #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input logic       clk,
  input logic       rst,
  dmem_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, BEAT2} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t state, state_n;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc, in_beat2;
  logic [1:0]    off, sz;
  logic          sgn, legal_ld, legal_st, fault_c, go_split;
  logic [AW-1:0] widx;
  logic [3:0]    mask;
  logic [7:0]    be8;
  logic [63:0]   wd64;

  // Split-access context captured on the first beat
  logic [31:0]   hold_w, hwd_q;
  logic [3:0]    hbe_q;
  logic [1:0]    off_q, sz_q;
  logic          sgn_q, ld_q, st_q;
  logic [AW-1:0] widx_q;

  logic [63:0]   src;
  logic [1:0]    roff, rsz;
  logic          rsgn;
  logic [31:0]   sh, ext;

  logic [3:0]    we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign acc           = bus.req_valid && bus.req_ready;

  always_comb begin
    off      = bus.addr[1:0];
    widx     = bus.addr[AW+1:2];
    legal_ld = bus.MEMR && !bus.MEMW && (bus.MEM_Ctrl <= 4'd4);
    legal_st = !bus.MEMR && bus.MEMW && (bus.MEM_Ctrl >= 4'd5) && (bus.MEM_Ctrl <= 4'd7);
    sgn      = (bus.MEM_Ctrl == 4'd0) || (bus.MEM_Ctrl == 4'd1);
    case (bus.MEM_Ctrl)
      4'd0, 4'd3, 4'd5: sz = 2'd0;
      4'd1, 4'd4, 4'd6: sz = 2'd1;
      default:          sz = 2'd2;
    endcase
    case (sz)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be8  = {4'b0000, mask} << off;
    wd64 = {32'd0, bus.dataW} << {off, 3'b000};
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [2:0] nbytes;
  always_comb begin
    nbytes   = (sz == 2'd0) ? 3'd1 : (sz == 2'd1) ? 3'd2 : 3'd4;
    fault_c  = 1'b0;
    go_split = acc && (legal_ld || legal_st) && (({1'b0, off} + nbytes) > 3'd4);
  end
  assign in_beat2 = (state == BEAT2);
`else
  always_comb begin
    fault_c  = (legal_ld || legal_st) &&
               (((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != 2'd0)));
    go_split = 1'b0;
  end
  assign in_beat2 = 1'b0;
`endif

  // Load path: the second beat sees the two words as one 64-bit little-endian span
  always_comb begin
    if (in_beat2) begin
      src  = {mem[widx_q + AW'(1)], hold_w};
      roff = off_q;
      rsz  = sz_q;
      rsgn = sgn_q;
    end else begin
      src  = {32'd0, mem[widx]};
      roff = off;
      rsz  = sz;
      rsgn = sgn;
    end
    sh = 32'(src >> {roff, 3'b000});
    case (rsz)
      2'd0:    ext = rsgn ? {{24{sh[7]}}, sh[7:0]}   : {24'd0, sh[7:0]};
      2'd1:    ext = rsgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    we = 4'b0000;
    wa = widx;
    wd = wd64[31:0];
    if (in_beat2) begin
      if (st_q) we = hbe_q;
      wa = widx_q + AW'(1);
      wd = hwd_q;
    end else if (acc && legal_st && !fault_c) begin
      we = be8[3:0];
    end
    if (rst) we = 4'b0000;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  always_comb begin
    state_n = state;
`ifdef DMEM_MISALIGN_SPLIT_EN
    case (state)
      IDLE:    if (go_split) state_n = BEAT2;
      BEAT2:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      bus.rsp_valid      <= 1'b0;
      bus.dataR          <= 32'd0;
      bus.misalign_fault <= 1'b0;
      hold_w             <= 32'd0;
      hwd_q              <= 32'd0;
      hbe_q              <= 4'd0;
      off_q              <= 2'd0;
      sz_q               <= 2'd0;
      sgn_q              <= 1'b0;
      ld_q               <= 1'b0;
      st_q               <= 1'b0;
      widx_q             <= '0;
    end else begin
      state              <= state_n;
      bus.rsp_valid      <= 1'b0;
      bus.dataR          <= 32'd0;
      bus.misalign_fault <= 1'b0;
      if (in_beat2) begin
        bus.rsp_valid <= 1'b1;
        bus.dataR     <= ld_q ? ext : 32'd0;
      end else if (acc) begin
        if (go_split) begin
          hold_w <= src[31:0];
          hwd_q  <= wd64[63:32];
          hbe_q  <= be8[7:4];
          off_q  <= off;
          sz_q   <= sz;
          sgn_q  <= sgn;
          ld_q   <= legal_ld;
          st_q   <= legal_st;
          widx_q <= widx;
        end else begin
          bus.rsp_valid      <= 1'b1;
          bus.misalign_fault <= fault_c;
          bus.dataR          <= (legal_ld && !fault_c) ? ext : 32'd0;
        end
      end
    end
  end

  // Address bits above the word index alias by design
  generate
    if (ADDR_W > AW + 2) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^bus.addr[ADDR_W-1:AW+2];
    end
  endgenerate
endmodule

// File: tb/tb_dmem_sync.sv
// Scoreboard bench for dmem_sync: driver pushes expected responses, negedge monitor pops and compares.
module tb_dmem_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_sync_if #(.ADDR_W(32)) bus();
  dmem_sync #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.rsp_valid) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rsp: got dataR=%h fault=%b at cycle %0d, required no response",
                   bus.dataR, bus.misalign_fault, cyc);
        end else begin
          e = sbq.pop_front();
          if (bus.dataR !== e.data || bus.misalign_fault !== e.fault || cyc != e.due) begin
            n_bad++;
            $display("FAIL %s: got dataR=%h fault=%b cycle=%0d, required dataR=%h fault=%b cycle=%0d",
                     e.name, bus.dataR, bus.misalign_fault, cyc, e.data, e.fault, e.due);
          end
        end
      end else begin
        n_cmp++;
        if (bus.dataR !== 32'd0 || bus.misalign_fault !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_outputs: got dataR=%h fault=%b, required 0/0",
                   bus.dataR, bus.misalign_fault);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // lat: cycles from acceptance edge to response; 0 means no response is expected
  task automatic issue(input string nm, input logic r, input logic w, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ef, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MEMR      = r;
    bus.MEMW      = w;
    bus.MEM_Ctrl  = c;
    bus.addr      = a;
    bus.dataW     = d;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ready_timeout: got req_ready=0 for %0d cycles, required 1", nm, n);
      bus.req_valid = 1'b0;
      return;
    end
    if (lat > 0) begin
      e.data  = ed;
      e.fault = ef;
      e.due   = cyc + lat;
      e.name  = nm;
      sbq.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.MEMR      = 1'b0;
    bus.MEMW      = 1'b0;
    bus.MEM_Ctrl  = 4'd0;
    bus.addr      = 32'd0;
    bus.dataW     = 32'd0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_dataR", bus.dataR, 32'd0);
    chk("rst_fault", {31'd0, bus.misalign_fault}, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    // Aligned loads/stores and extension
    issue("sw_0",    0, 1, 4'd7, 32'h0, 32'hAABBCCDD, 32'h0,        0, 1);
    issue("lw_0",    1, 0, 4'd2, 32'h0, 32'h0,        32'hAABBCCDD, 0, 1);
    issue("lb_3",    1, 0, 4'd0, 32'h3, 32'h0,        32'hFFFFFFAA, 0, 1);
    issue("lbu_3",   1, 0, 4'd3, 32'h3, 32'h0,        32'h000000AA, 0, 1);
    issue("lh_2",    1, 0, 4'd1, 32'h2, 32'h0,        32'hFFFFAABB, 0, 1);
    issue("lhu_0",   1, 0, 4'd4, 32'h0, 32'h0,        32'h0000CCDD, 0, 1);
    issue("lb_1",    1, 0, 4'd0, 32'h1, 32'h0,        32'hFFFFFFCC, 0, 1);
    issue("sw_4",    0, 1, 4'd7, 32'h4, 32'h0,        32'h0,        0, 1);
    issue("sb_5",    0, 1, 4'd5, 32'h5, 32'h0000017F, 32'h0,        0, 1);
    issue("lw_4_a",  1, 0, 4'd2, 32'h4, 32'h0,        32'h00007F00, 0, 1);
    issue("sh_6",    0, 1, 4'd6, 32'h6, 32'h00018001, 32'h0,        0, 1);
    issue("lw_4_b",  1, 0, 4'd2, 32'h4, 32'h0,        32'h80017F00, 0, 1);
    issue("lh_6",    1, 0, 4'd1, 32'h6, 32'h0,        32'hFFFF8001, 0, 1);
    issue("lhu_6",   1, 0, 4'd4, 32'h6, 32'h0,        32'h00008001, 0, 1);
    issue("alias_1000",  1, 0, 4'd2, 32'h00001000, 32'h0, 32'hAABBCCDD, 0, 1);
    issue("alias_hi",    1, 0, 4'd2, 32'hFFFF1000, 32'h0, 32'hAABBCCDD, 0, 1);

    // Illegal combinations are acknowledged no-ops
    issue("ill_rw",      1, 1, 4'd7,  32'h0, 32'h0, 32'h0, 0, 1);
    issue("ill_ld_code", 1, 0, 4'd5,  32'h0, 32'h0, 32'h0, 0, 1);
    issue("ill_st_code", 0, 1, 4'd0,  32'h0, 32'h0, 32'h0, 0, 1);
    issue("ill_st_lw",   0, 1, 4'd2,  32'h0, 32'h0, 32'h0, 0, 1);
    issue("ill_ctrl9",   0, 1, 4'd9,  32'h0, 32'h0, 32'h0, 0, 1);
    issue("ill_ctrl15",  1, 0, 4'd15, 32'h0, 32'h0, 32'h0, 0, 1);
    issue("ill_none",    0, 0, 4'd2,  32'h0, 32'h0, 32'h0, 0, 1);
    issue("lw_0_after_ill", 1, 0, 4'd2, 32'h0, 32'h0, 32'hAABBCCDD, 0, 1);

`ifndef DMEM_MISALIGN_SPLIT_EN
    issue("sh_1_fault",  0, 1, 4'd6, 32'h1, 32'h0000BEEF, 32'h0, 1, 1);
    issue("lw_0_kept",   1, 0, 4'd2, 32'h0, 32'h0, 32'hAABBCCDD, 0, 1);
    issue("lw_2_fault",  1, 0, 4'd2, 32'h2, 32'h0, 32'h0, 1, 1);
    issue("lh_3_fault",  1, 0, 4'd1, 32'h3, 32'h0, 32'h0, 1, 1);
    issue("sw_6_fault",  0, 1, 4'd7, 32'h6, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue("lw_4_kept",   1, 0, 4'd2, 32'h4, 32'h0, 32'h80017F00, 0, 1);
    issue("lhu_5_fault", 1, 0, 4'd4, 32'h5, 32'h0, 32'h0, 1, 1);
    issue("lb_5",        1, 0, 4'd0, 32'h5, 32'h0, 32'h0000007F, 0, 1);
`else
    issue("sw_10",       0, 1, 4'd7, 32'h10, 32'h0, 32'h0, 0, 1);
    issue("sh_11",       0, 1, 4'd6, 32'h11, 32'h0000BEEF, 32'h0, 0, 1);
    issue("lw_10",       1, 0, 4'd2, 32'h10, 32'h0, 32'h00BEEF00, 0, 1);
    issue("lh_11",       1, 0, 4'd1, 32'h11, 32'h0, 32'hFFFFBEEF, 0, 1);
    issue("sw_8",        0, 1, 4'd7, 32'h8, 32'h0, 32'h0, 0, 1);
    issue("sw_6_split",  0, 1, 4'd7, 32'h6, 32'h11223344, 32'h0, 0, 2);
    @(negedge clk);
    chk("split_ready_low", {31'd0, bus.req_ready}, 32'd0);
    issue("lw_6_split",  1, 0, 4'd2, 32'h6, 32'h0, 32'h11223344, 0, 2);
    issue("lw_4_split",  1, 0, 4'd2, 32'h4, 32'h0, 32'h33447F00, 0, 1);
    issue("lw_8_split",  1, 0, 4'd2, 32'h8, 32'h0, 32'h00001122, 0, 1);
    issue("lh_7_cross",  1, 0, 4'd1, 32'h7, 32'h0, 32'h00002233, 0, 2);
    issue("lw_1_cross",  1, 0, 4'd2, 32'h1, 32'h0, 32'h00AABBCC, 0, 2);
    issue("sw_ffc",      0, 1, 4'd7, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 1);
    issue("lw_ffe_wrap", 1, 0, 4'd2, 32'hFFE, 32'h0, 32'hCCDDCAFE, 0, 2);
    issue("lh_fff_wrap", 1, 0, 4'd1, 32'hFFF, 32'h0, 32'hFFFFDDCA, 0, 2);

    // Reset during the second beat of a split store
    issue("sw_4_clr",    0, 1, 4'd7, 32'h4, 32'h0, 32'h0, 0, 1);
    issue("sw_8_clr",    0, 1, 4'd7, 32'h8, 32'h0, 32'h0, 0, 1);
    idle();
    repeat (2) @(negedge clk);
    issue("sw_6_rst",    0, 1, 4'd7, 32'h6, 32'h55667788, 32'h0, 0, 0);
    #1;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_beat2_rst", {31'd0, bus.req_ready}, 32'd1);
    chk("no_rsp_after_beat2_rst", {31'd0, bus.rsp_valid}, 32'd0);
    issue("lw_4_partial", 1, 0, 4'd2, 32'h4, 32'h0, 32'h77880000, 0, 1);
    issue("lw_8_partial", 1, 0, 4'd2, 32'h8, 32'h0, 32'h00000000, 0, 1);
`endif

    idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_sync.md
# dmem_sync

Parametrised, synchronous-read successor to the pipeline's data memory. It sits in the MEM stage and serves RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) through a valid/ready request and a registered one-cycle response. It stores data as byte-enabled 32-bit words. Word-crossing misaligned accesses are either split into two beats or faulted.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 2 (1024 = 4 KiB).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- MEMR  in  1  load request.
- MEMW  in  1  store request.
- MEM_Ctrl  in  4  access code:
  - 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU (loads).
  - 5 SB, 6 SH, 7 SW (stores).
  - 8–15 illegal.
- addr  in  ADDR_W  byte address.
- dataW  in  32  store data, taken from the LSBs.
- rsp_valid  out  1  one-cycle response pulse.
- dataR  out  32  load result; sign- or zero-extended per MEM_Ctrl.
- misalign_fault  out  1  qualifies rsp_valid.

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte offset is off = addr[1:0]. Access size is 1, 2 or 4 bytes.
- Request classes:
  - Legal: MEMR=1, MEMW=0, MEM_Ctrl 0–4; or MEMR=0, MEMW=1, MEM_Ctrl 5–7.
  - Anything else is a no-op: accepted, rsp_valid pulses, dataR=0, no write, misalign_fault=0.
- Natural misalignment: halfword with off[0]=1, or word with off≠0.
- Crossing: off + size > 4.
- FSM has two states, IDLE and BEAT2. req_ready = (state==IDLE) && !rst.
- IDLE, accepting a non-crossing request:
  - Loads read the word and extract/extend the bytes.
  - Stores write only the addressed bytes (byte enables).
  - State stays IDLE.
- IDLE, accepting a crossing request (split mode):
  - Beat 1 accesses word W: loads capture it in a holding register; stores write bytes off..3.
  - State goes to BEAT2.
- BEAT2:
  - Accesses word (W+1) mod DEPTH_WORDS; stores write the remaining low bytes.
  - Loads assemble the result from the holding register plus the new word.
  - Returns to IDLE.
- Memory contents are not reset and are undefined at power-up.
- Reset mid-BEAT2: state returns to IDLE and no response is issued. A first-beat store write already committed remains (partial write).

## Timing
- Reset values: rsp_valid=0, dataR=0, misalign_fault=0, state=IDLE. req_ready is 0 while rst is high and 1 in the first cycle after release.
- Non-crossing request accepted at edge N: rsp_valid=1 during cycle N+1 with dataR valid. Stores write at edge N and also pulse rsp_valid at N+1 as an acknowledge.
- Split request accepted at edge N: req_ready=0 during cycle N+1, second beat at edge N+1, rsp_valid during cycle N+2. Throughput is one split per 2 cycles.
- Back-to-back non-crossing requests sustain one per cycle.
- Store followed by a load to the same word on the next cycle returns the new data. There is no read-before-write hazard.
- Outside a response cycle: dataR=0, misalign_fault=0.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined:
  - Naturally misaligned but non-crossing accesses complete in one beat.
  - Crossing accesses use the two-beat split.
  - misalign_fault is never asserted.
- DMEM_MISALIGN_SPLIT_EN undefined:
  - Any naturally misaligned request completes in one cycle: rsp_valid at N+1, misalign_fault=1, dataR=0, no bytes written.
  - The BEAT2 state is not generated.

## Test plan
- Reset, then SW 0xAABBCCDD @0x0 followed by LW @0x0 -> rsp_valid at N+1 for each; LW dataR=0xAABBCCDD.
- LB @0x3, then LBU @0x3 (word 0 = 0xAABBCCDD) -> 0xFFFFFFAA, then 0x000000AA; LH @0x2 -> 0xFFFFAABB.
- With DMEM_MISALIGN_SPLIT_EN: SW 0x11223344 @0x6, then LW @0x6 ->
  - req_ready low for one cycle, rsp_valid at N+2.
  - Bytes 6..9 = 44,33,22,11; LW returns 0x11223344.
- Without DMEM_MISALIGN_SPLIT_EN: SH 0xBEEF @0x1 -> misalign_fault=1 at N+1, dataR=0, word 0 unchanged (0xAABBCCDD).
- Top-wrap with DEPTH_WORDS=1024 and split enabled: LW @0xFFE -> bytes 0xFFE, 0xFFF, 0x000, 0x001 assembled. Address 0x1000 aliases 0x000.
- Assert rst in the BEAT2 cycle of SW @0x6 -> no rsp_valid, req_ready=1 after release, bytes 6..7 written and 8..9 unchanged.
